// File: rtl/go_requester.sv
// rtl/go_requester.sv - debounced GO initiator for the counter FSM handshake
// Holds go until done rises, then waits for a stable release before re-arming.
module go_requester #(
  parameter logic [23:0] DEBOUNCE_CYCLES = 24'd120000,
  parameter logic [26:0] TIMEOUT_CYCLES  = 27'd72000000,
  parameter int unsigned RUN_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go_btn,
  input  logic                 done_in,
  output logic                 go,
  output logic                 busy,
  output logic [RUN_WIDTH-1:0] run_count,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, REQUEST, WAIT_RELEASE} state_t;

  localparam logic [26:0] DB_LAST = 27'(DEBOUNCE_CYCLES) - 27'd1;
  localparam logic [26:0] DB_FULL = 27'(DEBOUNCE_CYCLES);
  localparam logic [26:0] TO_LAST = TIMEOUT_CYCLES - 27'd1;

  state_t                 state_q;
  logic [26:0]            cnt_q;
  logic                   go_q;
  logic                   busy_q;
  logic [RUN_WIDTH-1:0]   run_q;
  logic                   terr_q;

  logic                   btn_s1_q, btn_s2_q;
  logic                   done_s1_q, done_s2_q, done_d_q;
  logic [1:0]             vld_q;
  logic                   arm_q;

  logic                   press;
  logic                   done_rise;

  assign press     = ~btn_s2_q;
  assign done_rise = done_s2_q & ~done_d_q;

  // A press is only accepted once a genuine release has passed through the
  // synchronizer since reset, so a button held across reset cannot fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q  <= 1'b1;
      btn_s2_q  <= 1'b1;
      done_s1_q <= 1'b0;
      done_s2_q <= 1'b0;
      done_d_q  <= 1'b0;
      vld_q     <= 2'b00;
      arm_q     <= 1'b0;
    end else begin
      btn_s1_q  <= go_btn;
      btn_s2_q  <= btn_s1_q;
      done_s1_q <= done_in;
      done_s2_q <= done_s1_q;
      done_d_q  <= done_s2_q;
      vld_q     <= {vld_q[0], 1'b1};
      if (vld_q[1] && !press) begin
        arm_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      run_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          go_q <= 1'b0;
          if (press && arm_q) begin
            state_q <= DEBOUNCE;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!press) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= REQUEST;
            cnt_q   <= '0;
            go_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 27'd1;
          end
        end
        REQUEST: begin
          // Completion takes priority over a coincident timeout.
          if (done_rise) begin
            state_q <= WAIT_RELEASE;
            cnt_q   <= '0;
            go_q    <= 1'b0;
            run_q   <= run_q + 1'b1;
          end else if (cnt_q == TO_LAST) begin
            state_q <= WAIT_RELEASE;
            cnt_q   <= '0;
            go_q    <= 1'b0;
            terr_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 27'd1;
          end
        end
        WAIT_RELEASE: begin
          go_q <= 1'b0;
          if (press) begin
            cnt_q <= '0;
          end else if (cnt_q == DB_FULL) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 27'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          go_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign go          = go_q;
  assign busy        = busy_q;
  assign run_count   = run_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_go_requester.sv
// tb/tb_go_requester.sv - self-checking bench for go_requester
// Run-length reference model plus hand-computed edge-latency checks.
module tb_go_requester;

  localparam int DB = 4;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       go_btn;
  logic       done_in;
  logic       go;
  logic       busy;
  logic [7:0] run_count;
  logic       timeout_err;

  int vectors = 0;
  int miscompares = 0;

  go_requester #(
    .DEBOUNCE_CYCLES(24'd4),
    .TIMEOUT_CYCLES (27'd20),
    .RUN_WIDTH      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go_btn     (go_btn),
    .done_in    (done_in),
    .go         (go),
    .busy       (busy),
    .run_count  (run_count),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Model: inputs reach decision logic two edges after sampling; a request
  // needs DB+1 consecutive press decisions, a release needs DB+1 quiet ones.
  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_REL  = 2;

  int bh0, bh1;
  int dh0, dh1, dh2;
  int m_mode, m_run, m_runs;
  bit m_err, m_armed;
  bit m_press, m_rise;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bh0 = -1; bh1 = -1;
      dh0 = 0; dh1 = 0; dh2 = 0;
      m_mode = M_IDLE; m_run = 0; m_runs = 0;
      m_err = 0; m_armed = 0;
    end else begin
      m_press = (bh1 == 0);
      m_rise  = (dh1 == 1) && (dh2 == 0);
      if (m_mode == M_IDLE) begin
        if (m_press && m_armed) begin
          m_run = m_run + 1;
          if (m_run == DB + 1) begin m_mode = M_REQ; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end else if (m_mode == M_REQ) begin
        if (m_rise) begin
          m_runs = m_runs + 1; m_mode = M_REL; m_run = 0;
        end else begin
          m_run = m_run + 1;
          if (m_run == TO) begin m_err = 1; m_mode = M_REL; m_run = 0; end
        end
      end else begin
        if (m_press) m_run = 0;
        else begin
          m_run = m_run + 1;
          if (m_run == DB + 1) begin m_mode = M_IDLE; m_run = 0; end
        end
      end
      if (bh1 == 1) m_armed = 1;
      bh1 = bh0; bh0 = int'(go_btn);
      dh2 = dh1; dh1 = dh0; dh0 = int'(done_in);
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp("model_go",   32'(go),          32'(m_mode == M_REQ));
      cmp("model_busy", 32'(busy),        32'((m_mode != M_IDLE) || (m_run > 0)));
      cmp("model_runs", 32'(run_count),   32'(m_runs % 256));
      cmp("model_terr", 32'(timeout_err), 32'(m_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_run();
    go_btn = 1'b0; tick(8);
    done_in = 1'b1; tick(4);
    done_in = 1'b0; go_btn = 1'b1; tick(8);
  endtask

  initial begin
    rst = 1'b1; go_btn = 1'b1; done_in = 1'b0;
    #12;
    cmp("rst_go", 32'(go), 0);
    cmp("rst_busy", 32'(busy), 0);
    cmp("rst_runs", 32'(run_count), 0);
    cmp("rst_terr", 32'(timeout_err), 0);
    @(posedge clk); #2; rst = 1'b0;
    tick(5);

    // Clean press: busy on 3rd sampling edge, go on 7th
    go_btn = 1'b0;
    tick(2); cmp("press_busy_e2", 32'(busy), 0);
    tick(1); cmp("press_busy_e3", 32'(busy), 1);
    tick(3); cmp("press_go_e6", 32'(go), 0);
    tick(1); cmp("press_go_e7", 32'(go), 1);
    cmp("press_runs", 32'(run_count), 0);

    // Done handshake: go falls on 3rd edge sampling done high
    done_in = 1'b1;
    tick(2); cmp("done_go_e2", 32'(go), 1);
    tick(1); cmp("done_go_e3", 32'(go), 0);
    cmp("done_runs", 32'(run_count), 1);
    tick(2); done_in = 1'b0;
    tick(50); cmp("held_go", 32'(go), 0);
    cmp("held_busy", 32'(busy), 1);
    go_btn = 1'b1;
    tick(6); cmp("rel_busy_e6", 32'(busy), 1);
    tick(1); cmp("rel_busy_e7", 32'(busy), 0);
    tick(3);

    // Bounce: aborted debounce, go 7 edges after final falling sample
    go_btn = 1'b0; tick(3);
    go_btn = 1'b1; tick(1);
    go_btn = 1'b0;
    tick(6); cmp("bounce_go_e6", 32'(go), 0);
    tick(1); cmp("bounce_go_e7", 32'(go), 1);
    done_in = 1'b1; tick(5); done_in = 1'b0;
    go_btn = 1'b1; tick(10);
    cmp("bounce_runs", 32'(run_count), 2);

    // Timeout after 20 edges in request
    go_btn = 1'b0; tick(7);
    cmp("to_go_start", 32'(go), 1);
    tick(19); cmp("to_go_e19", 32'(go), 1);
    tick(1); cmp("to_go_e20", 32'(go), 0);
    cmp("to_terr", 32'(timeout_err), 1);
    cmp("to_runs", 32'(run_count), 2);
    go_btn = 1'b1; tick(10);
    do_run();
    cmp("to2_runs", 32'(run_count), 3);
    cmp("to2_terr", 32'(timeout_err), 1);

    // Stale done level ignored until it falls and rises again
    done_in = 1'b1; tick(5);
    go_btn = 1'b0; tick(7);
    tick(10); cmp("stale_go", 32'(go), 1);
    done_in = 1'b0; tick(3);
    done_in = 1'b1; tick(3);
    cmp("stale_go_done", 32'(go), 0);
    cmp("stale_runs", 32'(run_count), 4);
    done_in = 1'b0; go_btn = 1'b1; tick(10);

    // Wrap at 256 completions
    for (int i = 0; i < 251; i++) do_run();
    cmp("wrap_255", 32'(run_count), 255);
    do_run();
    cmp("wrap_0", 32'(run_count), 0);

    // Async reset mid-request with button held through reset
    do_run();
    go_btn = 1'b0; tick(10);
    cmp("ar_go_before", 32'(go), 1);
    #2; rst = 1'b1; #1;
    cmp("ar_go", 32'(go), 0);
    cmp("ar_busy", 32'(busy), 0);
    cmp("ar_runs", 32'(run_count), 0);
    cmp("ar_terr", 32'(timeout_err), 0);
    @(posedge clk); #2; rst = 1'b0;
    tick(30);
    cmp("ar_held_go", 32'(go), 0);
    cmp("ar_held_busy", 32'(busy), 0);
    go_btn = 1'b1; tick(10);
    go_btn = 1'b0; tick(7);
    cmp("ar_repress_go", 32'(go), 1);
    done_in = 1'b1; tick(4); done_in = 1'b0;
    go_btn = 1'b1; tick(10);
    cmp("ar_final_runs", 32'(run_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
